// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - ball position engine: prescaled fall, clamped steering, land/pause/respawn
// Outputs are registered directly from the state registers; x/y candidates are formed combinationally.
module ball_motion_ctrl #(
   parameter int X_W         = 10,
   parameter int Y_W         = 9,
   parameter int X_MIN       = 84,
   parameter int X_MAX       = 596,
   parameter int X_INIT      = 340,
   parameter int Y_TOP       = 0,
   parameter int Y_BOTTOM    = 479,
   parameter int X_STEP      = 1,
   parameter int Y_STEP      = 1,
   parameter int TICK_DIV    = 1,
   parameter int PAUSE_TICKS = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           left,
   input  logic           right,
   input  logic           fast,
   output logic [X_W-1:0] x_ball,
   output logic [Y_W-1:0] y_ball,
   output logic [1:0]     state,
   output logic           landed
);

   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PCW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
   localparam int XE  = X_W + 1;
   localparam int YE  = Y_W + 1;

   localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV - 1);
   localparam logic [PCW-1:0] PAUSE_LAST = PCW'(PAUSE_TICKS - 1);
   localparam logic [XE-1:0]  XMIN_E     = XE'(X_MIN);
   localparam logic [XE-1:0]  XMAX_E     = XE'(X_MAX);
   localparam logic [X_W-1:0] XMIN_V     = X_W'(X_MIN);
   localparam logic [X_W-1:0] XMAX_V     = X_W'(X_MAX);
   localparam logic [X_W-1:0] XINIT_V    = X_W'(X_INIT);
   localparam logic [X_W-1:0] XSTEP_V    = X_W'(X_STEP);
   localparam logic [X_W-1:0] XSTEP2_V   = X_W'(2 * X_STEP);
   localparam logic [YE-1:0]  YSTEP_E    = YE'(Y_STEP);
   localparam logic [YE-1:0]  YBOT_E     = YE'(Y_BOTTOM);
   localparam logic [Y_W-1:0] YBOT_V     = Y_W'(Y_BOTTOM);
   localparam logic [Y_W-1:0] YTOP_V     = Y_W'(Y_TOP);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t         state_q;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           landed_q;
   logic [TCW-1:0] tick_cnt_q;
   logic [PCW-1:0] pause_cnt_q;

   logic           tick;
   logic           floor_hit;
   logic [X_W-1:0] step_v;
   logic [XE-1:0]  x_add_e;
   logic [YE-1:0]  y_sum_e;

   assign tick = (tick_cnt_q == TICK_LAST);

   // Comparisons carry one extra bit so neither clamp can be defeated by wrap-around.
   always_comb begin
      step_v    = fast ? XSTEP2_V : XSTEP_V;
      x_add_e   = {1'b0, x_q} + {1'b0, step_v};
      x_d       = x_q;
      if (left && !right) begin
         x_d = ({1'b0, x_q} >= (XMIN_E + {1'b0, step_v})) ? (x_q - step_v) : XMIN_V;
      end else if (right && !left) begin
         x_d = (x_add_e <= XMAX_E) ? x_add_e[X_W-1:0] : XMAX_V;
      end
      y_sum_e   = {1'b0, y_q} + YSTEP_E;
      floor_hit = (y_sum_e >= YBOT_E);
      y_d       = floor_hit ? YBOT_V : y_sum_e[Y_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         x_q         <= XINIT_V;
         y_q         <= YTOP_V;
         landed_q    <= 1'b0;
         tick_cnt_q  <= '0;
         pause_cnt_q <= '0;
      end else begin
         landed_q   <= 1'b0;
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               x_q <= XINIT_V;
               y_q <= YTOP_V;
               if (start) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (tick) begin
                  x_q <= x_d;
                  y_q <= y_d;
                  if (floor_hit) begin
                     landed_q    <= 1'b1;
                     state_q     <= ST_PAUSE;
                     pause_cnt_q <= '0;
                  end
               end
            end
            ST_PAUSE: begin
               if (tick) begin
                  if (pause_cnt_q == PAUSE_LAST) begin
                     y_q         <= YTOP_V;
                     pause_cnt_q <= '0;
                     state_q     <= ST_RUN;
                  end else begin
                     pause_cnt_q <= pause_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign x_ball = x_q;
   assign y_ball = y_q;
   assign state  = state_q;
   assign landed = landed_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - directed bench for ball_motion_ctrl
// u0 uses default parameters; u1 is the slow-tick, short-floor variant.
module tb_ball_motion_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, left, right, fast;
   logic [9:0] x0;
   logic [8:0] y0;
   logic [1:0] st0;
   logic       ld0;

   logic       reset1, start1, left1, right1, fast1;
   logic [9:0] x1;
   logic [8:0] y1;
   logic [1:0] st1;
   logic       ld1;

   int checks = 0;
   int errors = 0;

   ball_motion_ctrl u0 (
      .clk(clk), .reset(reset), .start(start), .left(left), .right(right), .fast(fast),
      .x_ball(x0), .y_ball(y0), .state(st0), .landed(ld0)
   );

   ball_motion_ctrl #(
      .TICK_DIV(4), .Y_STEP(3), .Y_BOTTOM(10), .PAUSE_TICKS(2)
   ) u1 (
      .clk(clk), .reset(reset1), .start(start1), .left(left1), .right(right1), .fast(fast1),
      .x_ball(x1), .y_ball(y1), .state(st1), .landed(ld1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk0(input string tag, input int xe, input int ye, input int se, input int le);
      check({tag, ".x"}, 32'(x0), 32'(xe));
      check({tag, ".y"}, 32'(y0), 32'(ye));
      check({tag, ".state"}, 32'(st0), 32'(se));
      check({tag, ".landed"}, 32'(ld0), 32'(le));
   endtask

   task automatic chk1(input string tag, input int xe, input int ye, input int se, input int le);
      check({tag, ".x"}, 32'(x1), 32'(xe));
      check({tag, ".y"}, 32'(y1), 32'(ye));
      check({tag, ".state"}, 32'(st1), 32'(se));
      check({tag, ".landed"}, 32'(ld1), 32'(le));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; left = 1'b1; right = 1'b0; fast = 1'b0;
      reset1 = 1'b1; start1 = 1'b0; left1 = 1'b0; right1 = 1'b0; fast1 = 1'b0;

      step();
      step();
      chk0("reset", 340, 0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk0("idle", 340, 0, 0, 0);
      end

      left = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk0("run_entry", 340, 0, 1, 0);
      for (int k = 1; k <= 478; k++) begin
         step();
         chk0("fall", 340, k, 1, 0);
      end
      step();
      chk0("land", 340, 479, 2, 1);

      left = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk0("pause", 340, 479, 2, 0);
      end
      left = 1'b0;
      step();
      chk0("respawn", 340, 0, 1, 0);

      left = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         step();
         chk0("left_clamp", (k >= 256) ? 84 : 340 - k, k, 1, 0);
      end
      left = 1'b0;

      reset = 1'b1;
      step();
      chk0("reset_run", 340, 0, 0, 0);
      reset = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk0("run2", 340, 0, 1, 0);
      right = 1'b1;
      for (int k = 1; k <= 255; k++) begin
         step();
         chk0("right", 340 + k, k, 1, 0);
      end
      fast = 1'b1;
      step();
      chk0("fast_clamp", 596, 256, 1, 0);
      step();
      chk0("fast_hold", 596, 257, 1, 0);
      left = 1'b1;
      step();
      chk0("both", 596, 258, 1, 0);
      right = 1'b0;
      step();
      chk0("fast_left", 594, 259, 1, 0);
      left = 1'b0;
      fast = 1'b0;

      reset1 = 1'b0;
      start1 = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         int ye, se;
         step();
         start1 = 1'b0;
         ye = (c < 4) ? 0 : (c < 8) ? 3 : (c < 12) ? 6 : (c < 16) ? 9 : (c < 24) ? 10 : 0;
         se = (c < 16) ? 1 : (c < 24) ? 2 : 1;
         chk1("presc", 340, ye, se, (c == 16) ? 1 : 0);
      end
      for (int c = 25; c <= 41; c++) step();
      chk1("second_pause", 340, 10, 2, 0);
      reset1 = 1'b1;
      step();
      chk1("rst_pause", 340, 0, 0, 0);

      reset1 = 1'b0;
      start1 = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         step();
         start1 = 1'b0;
      end
      chk1("pre_land", 340, 9, 1, 0);
      reset1 = 1'b1;
      step();
      chk1("rst_land", 340, 0, 0, 0);
      reset1 = 1'b0;
      step();
      chk1("after_rst_land", 340, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
